ctrl_mc: RTL and testbench
==========================

CTRL_MC -- requirements
Module: ctrl_mc

Interface
REQ-001 The block SHALL have parameter TIMEOUT_W, default 4, giving the width of the memory-wait watchdog counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have decode inputs: opcode 5 bits (inst[6:2]), func3 3 bits, func7 7 bits, all driven from the external instruction register.
REQ-005 The block SHALL have status inputs: b 1 bit (branch-compare result), mem_rdy 1 bit (memory handshake acknowledge), muldiv_done 1 bit (M-unit completion).
REQ-006 The block SHALL have strobe outputs, 1 bit each: ir_we (instruction register load), pc_we (PC update), reg_wr (register write), mem_req (memory request), we (memory write enable), muldiv_start (M-unit launch), trap (fault flag).
REQ-007 The block SHALL have select outputs: pc_sel 2 bits, imm_type 3 bits, alu_op 4 bits, alu1_sel 1 bit, alu2_sel 1 bit, rd_sel 2 bits, mem_sel 1 bit.
REQ-008 The block SHALL have output state, 3 bits: the current FSM state, for debug use.

Function
REQ-009 FSM states and encodings SHALL be: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5, MULDIV=6.
REQ-010 In FETCH the block SHALL hold mem_req=1 and mem_sel=0 (PC address); on mem_rdy=1 it SHALL pulse ir_we=1 in that same cycle and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-011 In DECODE the block SHALL go to TRAP for any opcode outside {OP 01100, OP_IMM 00100, LUI 01101, AUIPC 00101, JAL 11011, JALR 11001, BRANCH 11000, LOAD 00000, STORE 01000}; otherwise it SHALL go to EXEC.
REQ-012 alu_op SHALL be: ADD 0000, SUB 0001 (OP with func3=000 and func7=0100000), XOR 0010, SLL 0101, SRL 0110, SRA 0111 (func3=101 with func7=0100000), SLT 1000; LOAD, STORE, JAL, JALR, AUIPC and LUI SHALL use ADD.
REQ-013 imm_type SHALL be: I=100 (OP_IMM, LOAD, JALR), S=011, U=001 (LUI, AUIPC), B=101, J=010, and 000 for OP.
REQ-014 alu1_sel SHALL be 1 (PC operand) for JAL, AUIPC and BRANCH, else 0; alu2_sel SHALL be 0 (rs2) for OP and BRANCH, else 1 (immediate).
REQ-015 EXEC SHALL go to MEM for LOAD and STORE; for BRANCH it SHALL assert pc_we=1 with pc_sel=01 (target) if b=1, else pc_sel=00 (+4), then go to FETCH; all other legal opcodes SHALL go to WB.
REQ-016 In MEM the block SHALL hold mem_req=1 and mem_sel=1, with we=1 only for STORE; on mem_rdy=1, LOAD SHALL go to WB and STORE SHALL assert pc_we=1 with pc_sel=00 and go to FETCH.
REQ-017 In WB the block SHALL assert reg_wr=1 and pc_we=1, with pc_sel=01 for JAL, 10 for JALR, else 00.
REQ-018 In WB rd_sel SHALL be 01 for LOAD, 10 (PC+4) for JAL/JALR, else 00 (ALU result); WB SHALL then go to FETCH.
REQ-019 A watchdog SHALL count cycles in FETCH/MEM with mem_rdy=0 and clear on any state change; when it reaches 2^TIMEOUT_W-1 with mem_rdy still 0, the next state SHALL be TRAP. If mem_rdy=1 in that same cycle, the handshake SHALL win.
REQ-020 TRAP SHALL hold trap=1 with all strobes 0 until rst.
REQ-021 Outside the states named above, all strobes SHALL be 0, and select outputs SHALL hold the decode of the current opcode.
REQ-022 With zero-wait memory (mem_rdy=1 whenever mem_req=1), an OP instruction SHALL take exactly 4 cycles, LOAD 5, STORE 4 and BRANCH 3.

Reset
REQ-023 While rst=1 the block SHALL force all strobes and trap to 0 and all selects to 0; on the first clk edge with rst=1, state SHALL become FETCH and the watchdog SHALL become 0.
REQ-024 rst asserted in any state, including mid-handshake or TRAP, SHALL abort the operation without a reg_wr or pc_we pulse in that cycle.

Configuration
REQ-025 Macro CTRL_MC_MULDIV_EN SHALL control the M extension.
REQ-026 When CTRL_MC_MULDIV_EN is defined, OP with func7=0000001 SHALL go from EXEC to MULDIV with a one-cycle muldiv_start=1 pulse on entry.
REQ-027 When CTRL_MC_MULDIV_EN is defined, MULDIV SHALL wait for muldiv_done=1, then go to WB with rd_sel=11; there is no timeout in MULDIV.
REQ-028 When CTRL_MC_MULDIV_EN is undefined, OP with func7=0000001 SHALL trap in DECODE, muldiv_start SHALL be tied to 0, and muldiv_done SHALL be ignored.

Verification
REQ-029 Bench SHALL cover: rst then OP/SUB (func7=0100000) with mem_rdy=1 -> states 0,1,2,4; alu_op=0001; reg_wr=1 in cycle 4 only.
REQ-030 Bench SHALL cover: LOAD with 3 wait cycles in MEM -> mem_req=1 and mem_sel=1 for 4 cycles; then WB with rd_sel=01.
REQ-031 Bench SHALL cover: BRANCH with b=1 and then b=0 -> pc_sel=01 and then pc_sel=00, each with pc_we=1 in EXEC and no reg_wr.
REQ-032 Bench SHALL cover: mem_rdy held 0 in FETCH with TIMEOUT_W=4 -> TRAP after 15 cycles with trap=1; rst then returns the FSM to FETCH.
REQ-033 Bench SHALL cover: opcode 11111 -> TRAP from DECODE, with no pc_we or reg_wr.
REQ-034 Bench SHALL cover: with CTRL_MC_MULDIV_EN, func7=0000001 and muldiv_done after 5 cycles -> one muldiv_start pulse, then WB with rd_sel=11; without the macro -> TRAP.

Source files
------------

// File: rtl/ctrl_mc.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing with a memory-wait watchdog.
// Optional M-extension sequencing (MULDIV state) is enabled by defining CTRL_MC_MULDIV_EN.
module ctrl_mc #(
   parameter int TIMEOUT_W = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] opcode,
   input  logic [2:0] func3,
   input  logic [6:0] func7,
   input  logic       b,
   input  logic       mem_rdy,
   input  logic       muldiv_done,
   output logic       ir_we,
   output logic       pc_we,
   output logic       reg_wr,
   output logic       mem_req,
   output logic       we,
   output logic       muldiv_start,
   output logic       trap,
   output logic [1:0] pc_sel,
   output logic [2:0] imm_type,
   output logic [3:0] alu_op,
   output logic       alu1_sel,
   output logic       alu2_sel,
   output logic [1:0] rd_sel,
   output logic       mem_sel,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5,
      S_MULDIV = 3'd6
   } state_t;

   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_OPIMM  = 5'b00100;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   // Last count before the watchdog fires: the wait cycle that would bring it to 2^W-1.
   localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

   state_t               st;
   logic [TIMEOUT_W-1:0] wd;

   logic is_op, is_opimm, is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
   logic is_md, legal, wd_last;
   logic [3:0] dec_alu;
   logic [2:0] dec_imm;
   logic [1:0] dec_rd;

   assign is_op     = (opcode == OPC_OP);
   assign is_opimm  = (opcode == OPC_OPIMM);
   assign is_lui    = (opcode == OPC_LUI);
   assign is_auipc  = (opcode == OPC_AUIPC);
   assign is_jal    = (opcode == OPC_JAL);
   assign is_jalr   = (opcode == OPC_JALR);
   assign is_branch = (opcode == OPC_BRANCH);
   assign is_load   = (opcode == OPC_LOAD);
   assign is_store  = (opcode == OPC_STORE);

`ifdef CTRL_MC_MULDIV_EN
   assign is_md = is_op && (func7 == F7_MULDIV);
   assign legal = is_op | is_opimm | is_lui | is_auipc | is_jal | is_jalr |
                  is_branch | is_load | is_store;
`else
   assign is_md = 1'b0;
   assign legal = (is_op && (func7 != F7_MULDIV)) | is_opimm | is_lui | is_auipc |
                  is_jal | is_jalr | is_branch | is_load | is_store;
`endif

   assign wd_last = !mem_rdy && (wd == WD_LAST);

   always_comb begin
      dec_alu = 4'b0000;
      if (is_op || is_opimm) begin
         case (func3)
            3'b000:  dec_alu = (is_op && func7 == F7_ALT) ? 4'b0001 : 4'b0000;
            3'b100:  dec_alu = 4'b0010;
            3'b001:  dec_alu = 4'b0101;
            3'b101:  dec_alu = (func7 == F7_ALT) ? 4'b0111 : 4'b0110;
            3'b010:  dec_alu = 4'b1000;
            default: dec_alu = 4'b0000;
         endcase
      end
   end

   always_comb begin
      case (opcode)
         OPC_OPIMM, OPC_LOAD, OPC_JALR: dec_imm = 3'b100;
         OPC_STORE:                     dec_imm = 3'b011;
         OPC_LUI, OPC_AUIPC:            dec_imm = 3'b001;
         OPC_BRANCH:                    dec_imm = 3'b101;
         OPC_JAL:                       dec_imm = 3'b010;
         default:                       dec_imm = 3'b000;
      endcase
   end

   assign dec_rd = is_md              ? 2'b11 :
                   is_load            ? 2'b01 :
                   (is_jal | is_jalr) ? 2'b10 : 2'b00;

`ifdef CTRL_MC_MULDIV_EN
   logic md_start;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         st <= S_FETCH;
         wd <= '0;
`ifdef CTRL_MC_MULDIV_EN
         md_start <= 1'b0;
`endif
      end else begin
`ifdef CTRL_MC_MULDIV_EN
         md_start <= 1'b0;
`endif
         case (st)
            S_FETCH: begin
               if (mem_rdy)      st <= S_DECODE;
               else if (wd_last) st <= S_TRAP;
            end
            S_DECODE: st <= legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
               if (is_load || is_store) st <= S_MEM;
               else if (is_branch)      st <= S_FETCH;
`ifdef CTRL_MC_MULDIV_EN
               else if (is_md) begin
                  st       <= S_MULDIV;
                  md_start <= 1'b1;
               end
`endif
               else                     st <= S_WB;
            end
            S_MEM: begin
               if (mem_rdy)      st <= is_load ? S_WB : S_FETCH;
               else if (wd_last) st <= S_TRAP;
            end
            S_WB:   st <= S_FETCH;
            S_TRAP: st <= S_TRAP;
`ifdef CTRL_MC_MULDIV_EN
            S_MULDIV: if (muldiv_done) st <= S_WB;
`endif
            default: st <= S_TRAP;
         endcase
         // Count only uninterrupted waits; any exit from FETCH/MEM leaves it cleared.
         if ((st == S_FETCH || st == S_MEM) && !mem_rdy && !wd_last) wd <= wd + TIMEOUT_W'(1);
         else                                                        wd <= '0;
      end
   end

`ifdef CTRL_MC_MULDIV_EN
   assign muldiv_start = md_start & ~rst;
`else
   logic unused_md;
   assign unused_md    = muldiv_done;
   assign muldiv_start = 1'b0;
`endif

   always_comb begin
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      reg_wr   = 1'b0;
      mem_req  = 1'b0;
      we       = 1'b0;
      trap     = 1'b0;
      mem_sel  = 1'b0;
      pc_sel   = is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
      rd_sel   = dec_rd;
      imm_type = dec_imm;
      alu_op   = dec_alu;
      alu1_sel = is_jal | is_auipc | is_branch;
      alu2_sel = !(is_op | is_branch);
      case (st)
         S_FETCH: begin
            mem_req = 1'b1;
            ir_we   = mem_rdy;
         end
         S_EXEC: if (is_branch) begin
            pc_we  = 1'b1;
            pc_sel = b ? 2'b01 : 2'b00;
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_sel = 1'b1;
            we      = is_store;
            if (mem_rdy && is_store) begin
               pc_we  = 1'b1;
               pc_sel = 2'b00;
            end
         end
         S_WB: begin
            reg_wr = 1'b1;
            pc_we  = 1'b1;
         end
         S_TRAP:  trap = 1'b1;
         default: ;
      endcase
      if (rst) begin
         ir_we    = 1'b0;
         pc_we    = 1'b0;
         reg_wr   = 1'b0;
         mem_req  = 1'b0;
         we       = 1'b0;
         trap     = 1'b0;
         mem_sel  = 1'b0;
         pc_sel   = 2'b00;
         rd_sel   = 2'b00;
         imm_type = 3'b000;
         alu_op   = 4'b0000;
         alu1_sel = 1'b0;
         alu2_sel = 1'b0;
      end
   end

   assign state = st;

endmodule

// File: tb/tb_ctrl_mc.sv
// Self-checking bench for ctrl_mc: directed scenarios plus randomized instructions against
// a per-instruction state-path model built from the instruction class and wait counts.
module tb_ctrl_mc;

   localparam int WMAX = 15;  // 2^TIMEOUT_W - 1 with the default TIMEOUT_W = 4

   localparam int S_F = 0, S_D = 1, S_E = 2, S_M = 3, S_WB = 4, S_T = 5, S_MD = 6;

   localparam logic [4:0] OP = 5'b01100, OPI = 5'b00100, LUI = 5'b01101, AUIPC = 5'b00101,
                          JAL = 5'b11011, JALR = 5'b11001, BR = 5'b11000, LD = 5'b00000,
                          ST = 5'b01000;

   logic       clk, rst;
   logic [4:0] opcode;
   logic [2:0] func3;
   logic [6:0] func7;
   logic       b, mem_rdy, muldiv_done;
   logic       ir_we, pc_we, reg_wr, mem_req, we, muldiv_start, trap;
   logic [1:0] pc_sel, rd_sel;
   logic [2:0] imm_type, state;
   logic [3:0] alu_op;
   logic       alu1_sel, alu2_sel, mem_sel;

   int n_vec = 0;
   int n_err = 0;

   int st_q[$];
   bit rdy_q[$];
   bit done_q[$];

   ctrl_mc #(.TIMEOUT_W(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7), .b(b),
      .mem_rdy(mem_rdy), .muldiv_done(muldiv_done), .ir_we(ir_we), .pc_we(pc_we),
      .reg_wr(reg_wr), .mem_req(mem_req), .we(we), .muldiv_start(muldiv_start),
      .trap(trap), .pc_sel(pc_sel), .imm_type(imm_type), .alu_op(alu_op),
      .alu1_sel(alu1_sel), .alu2_sel(alu2_sel), .rd_sel(rd_sel), .mem_sel(mem_sel),
      .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   function automatic bit rb();
      return 1'($urandom);
   endfunction

   function automatic void push(int s, bit r, bit d);
      st_q.push_back(s);
      rdy_q.push_back(r);
      done_q.push_back(d);
   endfunction

   // Memory wait: w idle cycles then the handshake, unless the watchdog expires first.
   function automatic bit mem_phase(int s, int w);
      for (int i = 0; i < w && i < WMAX; i++) push(s, 1'b0, rb());
      if (w >= WMAX) return 1'b1;
      push(s, 1'b1, rb());
      return 1'b0;
   endfunction

   function automatic logic [3:0] m_alu(logic [4:0] opc, logic [2:0] f3, logic [6:0] f7);
      if (opc != OP && opc != OPI) return 4'b0000;
      case (f3)
         3'b000:  return (opc == OP && f7 == 7'b0100000) ? 4'b0001 : 4'b0000;
         3'b100:  return 4'b0010;
         3'b001:  return 4'b0101;
         3'b101:  return (f7 == 7'b0100000) ? 4'b0111 : 4'b0110;
         3'b010:  return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [2:0] m_imm(logic [4:0] opc);
      if (opc == OPI || opc == LD || opc == JALR) return 3'b100;
      if (opc == ST)                              return 3'b011;
      if (opc == LUI || opc == AUIPC)             return 3'b001;
      if (opc == BR)                              return 3'b101;
      if (opc == JAL)                             return 3'b010;
      return 3'b000;
   endfunction

   task automatic chk_reset_outputs();
      chk("rst_ir_we", 32'(ir_we), 0);   chk("rst_pc_we", 32'(pc_we), 0);
      chk("rst_reg_wr", 32'(reg_wr), 0); chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_we", 32'(we), 0);         chk("rst_mds", 32'(muldiv_start), 0);
      chk("rst_trap", 32'(trap), 0);     chk("rst_pc_sel", 32'(pc_sel), 0);
      chk("rst_imm", 32'(imm_type), 0);  chk("rst_alu_op", 32'(alu_op), 0);
      chk("rst_alu1", 32'(alu1_sel), 0); chk("rst_alu2", 32'(alu2_sel), 0);
      chk("rst_rd_sel", 32'(rd_sel), 0); chk("rst_mem_sel", 32'(mem_sel), 0);
   endtask

   // Two reset cycles with busy-looking inputs; rst is released at the start of the next cycle.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; mem_rdy = 1'b1; muldiv_done = 1'b1; b = 1'b1;
      #1 chk_reset_outputs();
      @(negedge clk);
      #1 chk_reset_outputs();
      chk("rst_state", 32'(state), S_F);
   endtask

   task automatic run_instr(input logic [4:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                            input logic bv, input int fw, input int mw, input int mdw);
      bit md, legal, ld, sd, br, to, r;
      int s, prev;
      logic [1:0] exp_pcs, exp_rd;
      md = (opc == OP) && (f7 == 7'b0000001);
      ld = (opc == LD);
      sd = (opc == ST);
      br = (opc == BR);
      legal = opc inside {OP, OPI, LUI, AUIPC, JAL, JALR, BR, LD, ST};
`ifndef CTRL_MC_MULDIV_EN
      if (md) legal = 1'b0;
`endif
      st_q.delete(); rdy_q.delete(); done_q.delete();
      to = mem_phase(S_F, fw);
      if (!to) begin
         push(S_D, rb(), rb());
         if (!legal) to = 1'b1;
         else begin
            push(S_E, rb(), rb());
            if (ld || sd) begin
               to = mem_phase(S_M, mw);
               if (!to && ld) push(S_WB, rb(), rb());
            end else if (md) begin
               for (int i = 0; i < mdw; i++) push(S_MD, rb(), 1'b0);
               push(S_MD, rb(), 1'b1);
               push(S_WB, rb(), rb());
            end else if (!br) push(S_WB, rb(), rb());
         end
      end
      if (to) repeat (2) push(S_T, rb(), rb());

      exp_pcs = (opc == JAL) ? 2'b01 : (opc == JALR) ? 2'b10 : 2'b00;
      exp_rd  = md ? 2'b11 : ld ? 2'b01 : (opc == JAL || opc == JALR) ? 2'b10 : 2'b00;
      prev = -1;
      for (int c = 0; c < st_q.size(); c++) begin
         @(negedge clk);
         rst = 1'b0; opcode = opc; func3 = f3; func7 = f7; b = bv;
         mem_rdy = rdy_q[c]; muldiv_done = done_q[c];
         #1;
         s = st_q[c];
         r = rdy_q[c];
         chk("state", 32'(state), 32'(s));
         chk("ir_we", 32'(ir_we), 32'(s == S_F && r));
         chk("mem_req", 32'(mem_req), 32'(s == S_F || s == S_M));
         if (s == S_F || s == S_M) chk("mem_sel", 32'(mem_sel), 32'(s == S_M));
         chk("we", 32'(we), 32'(s == S_M && sd));
         chk("pc_we", 32'(pc_we), 32'((s == S_E && br) || (s == S_M && sd && r) || s == S_WB));
         chk("reg_wr", 32'(reg_wr), 32'(s == S_WB));
         chk("trap", 32'(trap), 32'(s == S_T));
         chk("muldiv_start", 32'(muldiv_start), 32'(s == S_MD && prev != S_MD));
         if (s == S_E && br)       chk("pc_sel_br", 32'(pc_sel), 32'(bv ? 2'b01 : 2'b00));
         if (s == S_M && sd && r)  chk("pc_sel_st", 32'(pc_sel), 0);
         if (s == S_WB) begin
            chk("pc_sel_wb", 32'(pc_sel), 32'(exp_pcs));
            chk("rd_sel", 32'(rd_sel), 32'(exp_rd));
         end
         if (s == S_D && legal) begin
            chk("imm_type", 32'(imm_type), 32'(m_imm(opc)));
            chk("alu1_sel", 32'(alu1_sel), 32'(opc == JAL || opc == AUIPC || br));
            chk("alu2_sel", 32'(alu2_sel), 32'(!(opc == OP || br)));
            if (!br) chk("alu_op", 32'(alu_op), 32'(m_alu(opc, f3, f7)));
         end
         prev = s;
      end
      if (to) do_reset();
   endtask

   logic [4:0] ops[9] = '{OP, OPI, LUI, AUIPC, JAL, JALR, BR, LD, ST};
   logic [4:0] r_opc;
   logic [6:0] r_f7;

   initial begin
      rst = 1'b1; opcode = OP; func3 = '0; func7 = '0; b = 1'b0;
      mem_rdy = 1'b0; muldiv_done = 1'b0;
      do_reset();

      run_instr(OP, 3'b000, 7'b0100000, 1'b0, 0, 0, 0);   // SUB: 0,1,2,4
      run_instr(LD, 3'b010, 7'b0000000, 1'b0, 0, 3, 0);   // 3 MEM wait cycles
      run_instr(BR, 3'b000, 7'b0000000, 1'b1, 0, 0, 0);
      run_instr(BR, 3'b001, 7'b0000000, 1'b0, 0, 0, 0);
      run_instr(ST, 3'b010, 7'b0000000, 1'b0, 1, 2, 0);
      run_instr(JAL, 3'b000, 7'b0000000, 1'b0, 0, 0, 0);
      run_instr(JALR, 3'b000, 7'b0000000, 1'b0, 0, 0, 0);
      run_instr(OPI, 3'b101, 7'b0100000, 1'b0, 0, 0, 0);  // SRAI
      run_instr(OP, 3'b000, 7'b0000000, 1'b0, 14, 0, 0);  // handshake on the last allowed cycle
      run_instr(OP, 3'b000, 7'b0000000, 1'b0, 20, 0, 0);  // FETCH timeout
      run_instr(LD, 3'b000, 7'b0000000, 1'b0, 0, 15, 0);  // MEM timeout
      run_instr(5'b11111, 3'b000, 7'b0000000, 1'b0, 0, 0, 0);
      run_instr(OP, 3'b000, 7'b0000001, 1'b0, 0, 0, 5);   // MUL

      // Reset mid-handshake: store in MEM with mem_rdy=1 must not update the PC.
      run_instr(LUI, 3'b000, 7'b0000000, 1'b0, 0, 0, 0);
      opcode = ST;
      @(negedge clk); rst = 1'b0; mem_rdy = 1'b1;
      @(negedge clk); mem_rdy = 1'b0;
      @(negedge clk);
      @(negedge clk); rst = 1'b1; mem_rdy = 1'b1;
      #1;
      chk("abort_state", 32'(state), S_M);
      chk("abort_pc_we", 32'(pc_we), 0);
      chk("abort_mem_req", 32'(mem_req), 0);
      chk("abort_we", 32'(we), 0);
      @(negedge clk);
      #1 chk("abort_to_fetch", 32'(state), S_F);

      for (int n = 0; n < 40; n++) begin
         r_opc = ops[$urandom_range(0, 8)];
         if ($urandom_range(0, 9) == 0) r_opc = 5'($urandom);
         case ($urandom_range(0, 3))
            0:       r_f7 = 7'b0000000;
            1:       r_f7 = 7'b0100000;
            2:       r_f7 = 7'b0000001;
            default: r_f7 = 7'($urandom);
         endcase
         run_instr(r_opc, 3'($urandom), r_f7, rb(), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 4));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
